// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid handshake with one request in flight,
// and feeds the IF/ID register through a one-entry skid buffer. Define IF_FETCH_PERF_EN to add perf counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        skid_valid, skid_valid_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic [31:0] instr_n, pc_out_n;
  logic        valid_n;
  logic        deliver;

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= REQ;
      pc         <= RESET_PC;
      fetch_pc   <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      instr_o    <= '0;
      pc_o       <= '0;
      valid_o    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      fetch_pc   <= fetch_pc_n;
      skid_valid <= skid_valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      instr_o    <= instr_n;
      pc_o       <= pc_out_n;
      valid_o    <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    fetch_pc_n   = fetch_pc;
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    instr_n      = instr_o;
    pc_out_n     = pc_o;
    valid_n      = stall_i ? valid_o : 1'b0;
    deliver      = 1'b0;

    unique case (state)
      REQ: begin
        if (imem_gnt_i) begin
          fetch_pc_n = pc;
          pc_n       = pc + 32'd4;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (!stall_i) begin
            instr_n  = imem_rdata_i;
            pc_out_n = fetch_pc;
            valid_n  = 1'b1;
            deliver  = 1'b1;
            state_n  = REQ;
          end else begin
            skid_valid_n = 1'b1;
            skid_instr_n = imem_rdata_i;
            skid_pc_n    = fetch_pc;
            state_n      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          if (skid_valid) begin
            instr_n  = skid_instr;
            pc_out_n = skid_pc;
            valid_n  = 1'b1;
            deliver  = 1'b1;
          end
          skid_valid_n = 1'b0;
          state_n      = REQ;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) state_n = REQ;
      end
      default: state_n = REQ;
    endcase

    // Redirect wins over stall and any delivery; a granted or still-pending fetch must be drained.
    if (redirect_i) begin
      pc_n         = {redirect_pc_i[31:2], 2'b00};
      valid_n      = 1'b0;
      deliver      = 1'b0;
      instr_n      = instr_o;
      pc_out_n     = pc_o;
      skid_valid_n = 1'b0;
      unique case (state)
        REQ:     state_n = imem_gnt_i ? DRAIN : REQ;
        WAIT:    state_n = imem_rvalid_i ? REQ : DRAIN;
        DRAIN:   state_n = imem_rvalid_i ? REQ : DRAIN;
        default: state_n = REQ;
      endcase
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (deliver) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (stall_i && valid_o) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the instruction/PC pair captured by the IF/ID pipeline register. It owns the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding. It delivers each returned instruction with its PC and a valid flag. It absorbs downstream stalls with a one-entry skid buffer and handles branch/jump redirects from later stages by flushing and dropping stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
stall_i  input  1  downstream (IF/ID) cannot accept; hold outputs
redirect_i  input  1  redirect request from EX (taken branch/jump)
redirect_pc_i  input  32  redirect target; bits [1:0] ignored (forced 0)
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch word address (= current PC)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid (for the single outstanding request)
imem_rdata_i  input  32  instruction word
instr_o  output  32  instruction to IF/ID
pc_o  output  32  PC of instr_o
valid_o  output  1  instr_o/pc_o hold a valid instruction

Behaviour:
- Reset (async): pc<=RESET_PC; fetch_pc<=0; state<=REQ; skid empty; instr_o<=0; pc_o<=0; valid_o<=0. imem_req_o is combinational and may assert in the first cycle after reset deassertion.
- States: REQ, WAIT, HOLD, DRAIN.
- REQ: imem_req_o=1, imem_addr_o=pc. When gnt=1: fetch_pc<=pc; pc<=pc+4 (32-bit wrap, FFFF_FFFC+4=0); go to WAIT.
- WAIT: imem_req_o=0. When rvalid=1 and stall_i=0: instr_o<=rdata, pc_o<=fetch_pc, valid_o<=1; go to REQ. When rvalid=1 and stall_i=1: skid<={rdata,fetch_pc}; go to HOLD.
- HOLD: imem_req_o=0. When stall_i falls to 0: outputs<=skid, valid_o<=1, skid cleared; go to REQ.
- DRAIN: imem_req_o=0. Discard the next rvalid, then go to REQ. Outputs do not change.
- Output register rule: when stall_i=1, instr_o, pc_o and valid_o hold their values, except on redirect. When stall_i=0 and no instruction is delivered that cycle, valid_o<=0.
- Latency: with gnt in cycle N and rvalid in cycle N+1, valid_o is high in cycle N+2. Zero-wait throughput is 1 instruction per 2 cycles.
- Redirect (highest priority, overrides stall_i):
  - pc<={redirect_pc_i[31:2],2'b00}; valid_o<=0; skid cleared.
  - In WAIT without rvalid in the same cycle, or in REQ with gnt=1: go to DRAIN.
  - In WAIT with rvalid in the same cycle: drop the data and go to REQ.
  - In HOLD or DRAIN, or in REQ without gnt: go to REQ (DRAIN stays DRAIN if its response is still pending).
- Simultaneous stall release and rvalid in HOLD cannot occur, because nothing is outstanding in HOLD.
- Reset mid-operation: state returns to REQ immediately. A response from a pre-reset request is the memory's responsibility; the fetch unit ignores rvalid in REQ.
- rvalid in REQ, or gnt outside REQ: ignored.

Optional Feature:
IF_FETCH_PERF_EN. When defined, the unit adds output fetch_cnt_o[31:0] and output stall_cnt_o[31:0].
- fetch_cnt_o increments on every cycle where valid_o is written to 1.
- stall_cnt_o increments on every cycle where stall_i=1 and valid_o=1.
- Both counters clear on reset and wrap at 2^32.
When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h0000_0100, memory granting immediately with rvalid 1 cycle later -> imem_addr_o sequence 0x100, 0x104, 0x108; pc_o 0x100, 0x104, 0x108 with matching instr_o; valid_o pulses every 2nd cycle.
- stall_i=1 held 3 cycles while the response for 0x104 returns -> instr_o/pc_o frozen at the 0x100 pair; no imem_req_o in HOLD; after release, pc_o=0x104 next cycle and then request for 0x108.
- redirect_i=1 with redirect_pc_i=0x203 while in WAIT -> the next rvalid is discarded, valid_o=0, next imem_addr_o=0x200, then pc_o=0x200 delivered.
- redirect_i asserted with stall_i=1 and valid_o=1 -> valid_o=0 next cycle despite the stall; skid content is not delivered.
- Starting at pc=0xFFFF_FFFC -> delivered pc_o=0xFFFF_FFFC, then next request address 0x0000_0000.
- reset asserted during WAIT -> outputs zero immediately; after release, the first request is to RESET_PC.
